// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared widths, read-only register boundary and writeback source encoding
// for the per-thread register-file write port.
package reg_writeback_arbiter_pkg;
    localparam int DATA_BITS     = 8;
    localparam int REG_ADDR_BITS = 4;
    localparam int FIRST_RO_REG  = 13;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_CONST,
        WB_LSU
    } wb_src_e;
endpackage

// File: rtl/reg_writeback_arbiter_wb_fifo.sv
// Small synchronous FIFO buffering LSU load responses until the write port is free.
// Full/empty derive from the registered count only, so ready never depends on pop.
module reg_writeback_arbiter_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_entry,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_BITS = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count_q;
    logic                do_push;
    logic                do_pop;

    assign full       = (count_q == (PTR_BITS+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_BITS+1)'(1);
                2'b01:   count_q <= count_q - (PTR_BITS+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is data only and needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/reg_writeback_arbiter.sv
// Single write-port arbiter (ALU > CONST > buffered LSU) with pending-load scoreboard,
// LSU starvation stall and sticky read-only / source-conflict error flags.
module reg_writeback_arbiter #(
    parameter int DATA_BITS    = reg_writeback_arbiter_pkg::DATA_BITS,
    parameter int ADDR_BITS    = reg_writeback_arbiter_pkg::REG_ADDR_BITS,
    parameter int FIFO_DEPTH   = 2,
    parameter int FIRST_RO_REG = reg_writeback_arbiter_pkg::FIRST_RO_REG,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [ADDR_BITS-1:0]    alu_rd_addr,
    input  logic [DATA_BITS-1:0]    alu_data,
    input  logic                    const_valid,
    input  logic [ADDR_BITS-1:0]    const_rd_addr,
    input  logic [DATA_BITS-1:0]    const_data,
    input  logic                    load_issue,
    input  logic [ADDR_BITS-1:0]    load_issue_rd,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [ADDR_BITS-1:0]    lsu_rd_addr,
    input  logic [DATA_BITS-1:0]    lsu_data,
    output logic                    wb_enable,
    output logic [ADDR_BITS-1:0]    wb_rd_address,
    output logic [DATA_BITS-1:0]    wb_data,
    output logic [2**ADDR_BITS-1:0] pending_mask,
    output logic                    issue_stall,
    output logic                    ro_violation,
    output logic                    src_conflict
);
    import reg_writeback_arbiter_pkg::*;

    localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;
    localparam int CNT_BITS   = $clog2(STARVE_LIMIT + 1);

    function automatic logic is_ro(input logic [ADDR_BITS-1:0] addr);
        return int'(addr) >= FIRST_RO_REG;
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        if (v >= CNT_BITS'(STARVE_LIMIT)) return v;
        return v + CNT_BITS'(1);
    endfunction

    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [ENTRY_BITS-1:0]      head_entry;
    logic [ADDR_BITS-1:0]       head_addr;
    logic [DATA_BITS-1:0]       head_data;

    wb_src_e                    src_p0;
    logic [ADDR_BITS-1:0]       addr_p0;
    logic [DATA_BITS-1:0]       data_p0;
    logic                       ro_p0;
    logic                       vld_p0;
    logic [2**ADDR_BITS-1:0]    pending_next;
    logic [CNT_BITS-1:0]        wait_next;

    logic                       vld_p1;
    wb_src_e                    src_p1;
    logic [ADDR_BITS-1:0]       addr_p1;
    logic [DATA_BITS-1:0]       data_p1;
    logic [2**ADDR_BITS-1:0]    pending_p1;
    logic [CNT_BITS-1:0]        wait_cnt_p1;
    logic                       stall_p1;
    logic                       ro_err_p1;
    logic                       conflict_p1;
    logic                       ready_en_p1;

    assign lsu_ready = ready_en_p1 && !fifo_full;
    assign fifo_push = lsu_valid && lsu_ready;
    assign {head_addr, head_data} = head_entry;

    reg_writeback_arbiter_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_wb_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry ({lsu_rd_addr, lsu_data}),
        .pop        (fifo_pop),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Stage p0: source selection, scoreboard and starvation next-state
    always_comb begin
        src_p0  = WB_NONE;
        addr_p0 = '0;
        data_p0 = '0;
        if (alu_valid) begin
            src_p0  = WB_ALU;
            addr_p0 = alu_rd_addr;
            data_p0 = alu_data;
        end else if (const_valid) begin
            src_p0  = WB_CONST;
            addr_p0 = const_rd_addr;
            data_p0 = const_data;
        end else if (!fifo_empty) begin
            src_p0  = WB_LSU;
            addr_p0 = head_addr;
            data_p0 = head_data;
        end
    end

    assign fifo_pop  = (src_p0 == WB_LSU);
    assign ro_p0     = is_ro(addr_p0);
    assign vld_p0    = (src_p0 != WB_NONE) && !ro_p0;
    assign wait_next = ((fifo_count != '0) && !fifo_pop) ? sat_inc(wait_cnt_p1) : '0;

    // Clear lands as the LSU write retires; a same-cycle issue to that register wins.
    always_comb begin
        pending_next = pending_p1;
        if (vld_p1 && (src_p1 == WB_LSU)) pending_next[addr_p1] = 1'b0;
        if (load_issue && !is_ro(load_issue_rd)) pending_next[load_issue_rd] = 1'b1;
    end

    // Stage p1: registered write port and status
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1      <= 1'b0;
            src_p1      <= WB_NONE;
            addr_p1     <= '0;
            data_p1     <= '0;
            pending_p1  <= '0;
            wait_cnt_p1 <= '0;
            stall_p1    <= 1'b0;
            ro_err_p1   <= 1'b0;
            conflict_p1 <= 1'b0;
            ready_en_p1 <= 1'b0;
        end else begin
            vld_p1      <= vld_p0;
            src_p1      <= src_p0;
            addr_p1     <= addr_p0;
            data_p1     <= data_p0;
            pending_p1  <= pending_next;
            wait_cnt_p1 <= wait_next;
            stall_p1    <= (wait_next >= CNT_BITS'(STARVE_LIMIT));
            ro_err_p1   <= ro_err_p1 || ((src_p0 != WB_NONE) && ro_p0);
            conflict_p1 <= conflict_p1 || (alu_valid && const_valid);
            ready_en_p1 <= 1'b1;
        end
    end

    assign wb_enable     = vld_p1;
    assign wb_rd_address = addr_p1;
    assign wb_data       = data_p1;
    assign pending_mask  = pending_p1;
    assign issue_stall   = stall_p1;
    assign ro_violation  = ro_err_p1;
    assign src_conflict  = conflict_p1;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: inputs driven 1 time unit after each
// rising edge, registered outputs checked at that same point.
module tb_reg_writeback_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [AW-1:0] alu_rd_addr;
    logic [DW-1:0] alu_data;
    logic          const_valid;
    logic [AW-1:0] const_rd_addr;
    logic [DW-1:0] const_data;
    logic          load_issue;
    logic [AW-1:0] load_issue_rd;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd_addr;
    logic [DW-1:0] lsu_data;
    logic          wb_enable;
    logic [AW-1:0] wb_rd_address;
    logic [DW-1:0] wb_data;
    logic [15:0]   pending_mask;
    logic          issue_stall;
    logic          ro_violation;
    logic          src_conflict;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    reg_writeback_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd_addr   (alu_rd_addr),
        .alu_data      (alu_data),
        .const_valid   (const_valid),
        .const_rd_addr (const_rd_addr),
        .const_data    (const_data),
        .load_issue    (load_issue),
        .load_issue_rd (load_issue_rd),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd_addr   (lsu_rd_addr),
        .lsu_data      (lsu_data),
        .wb_enable     (wb_enable),
        .wb_rd_address (wb_rd_address),
        .wb_data       (wb_data),
        .pending_mask  (pending_mask),
        .issue_stall   (issue_stall),
        .ro_violation  (ro_violation),
        .src_conflict  (src_conflict)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid     = 1'b0;
        alu_rd_addr   = '0;
        alu_data      = '0;
        const_valid   = 1'b0;
        const_rd_addr = '0;
        const_data    = '0;
        load_issue    = 1'b0;
        load_issue_rd = '0;
        lsu_valid     = 1'b0;
        lsu_rd_addr   = '0;
        lsu_data      = '0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        step();
        step();
        check("rst_wb_en",    wb_enable,    0);
        check("rst_wb_data",  wb_data,      0);
        check("rst_ready",    lsu_ready,    0);
        check("rst_mask",     pending_mask, 0);
        check("rst_stall",    issue_stall,  0);
        check("rst_ro",       ro_violation, 0);
        check("rst_conflict", src_conflict, 0);
        reset = 1'b1;
        step();
        check("post_rst_ready", lsu_ready, 1);

        // 1: single ALU write, one-cycle pulse
        alu_valid = 1'b1; alu_rd_addr = 4'd3; alu_data = 8'h5A;
        step();
        idle();
        check("t1_en",   wb_enable,     1);
        check("t1_addr", wb_rd_address, 3);
        check("t1_data", wb_data,       8'h5A);
        step();
        check("t1_idle", wb_enable, 0);

        // 2: ALU and CONST collide
        alu_valid = 1'b1;   alu_rd_addr = 4'd1;   alu_data = 8'h11;
        const_valid = 1'b1; const_rd_addr = 4'd2; const_data = 8'h22;
        step();
        idle();
        check("t2_en",       wb_enable,     1);
        check("t2_addr",     wb_rd_address, 1);
        check("t2_data",     wb_data,       8'h11);
        check("t2_conflict", src_conflict,  1);
        step();
        check("t2_no_const", wb_enable,     0);
        check("t2_sticky",   src_conflict,  1);

        // 3: scoreboard across a load
        load_issue = 1'b1; load_issue_rd = 4'd5;
        step();
        idle();
        check("t3_mask_set", pending_mask, 16'h0020);
        lsu_valid = 1'b1; lsu_rd_addr = 4'd5; lsu_data = 8'hC3;
        step();
        idle();
        check("t3_n1_en",   wb_enable,    0);
        check("t3_n1_mask", pending_mask, 16'h0020);
        step();
        check("t3_n2_en",   wb_enable,     1);
        check("t3_n2_addr", wb_rd_address, 5);
        check("t3_n2_data", wb_data,       8'hC3);
        check("t3_n2_mask", pending_mask,  16'h0020);
        step();
        check("t3_n3_mask", pending_mask, 16'h0000);
        check("t3_n3_en",   wb_enable,    0);

        // 4: ALU starves two buffered loads, then releases them
        for (int i = 0; i < 7; i++) begin
            alu_valid = 1'b1; alu_rd_addr = 4'd1; alu_data = 8'(8'h10 + i);
            lsu_valid = (i < 2);
            lsu_rd_addr = (i == 0) ? 4'd6 : 4'd7;
            lsu_data    = (i == 0) ? 8'hA1 : 8'hB2;
            step();
            idle();
            check("t4_alu_data", wb_data,     8'(8'h10 + i));
            check("t4_ready",    lsu_ready,   (i + 1 < 2) ? 1 : 0);
            check("t4_stall",    issue_stall, (i + 1 >= 5) ? 1 : 0);
        end
        check("t4_drop_stall", issue_stall, 1);
        step();
        check("t4_a_en",    wb_enable,     1);
        check("t4_a_addr",  wb_rd_address, 6);
        check("t4_a_data",  wb_data,       8'hA1);
        check("t4_a_stall", issue_stall,   0);
        check("t4_a_ready", lsu_ready,     1);
        step();
        check("t4_b_addr", wb_rd_address, 7);
        check("t4_b_data", wb_data,       8'hB2);
        step();
        check("t4_drained", wb_enable, 0);

        // 5: writes to read-only registers
        const_valid = 1'b1; const_rd_addr = 4'd14; const_data = 8'h77;
        lsu_valid = 1'b1;   lsu_rd_addr = 4'd15;   lsu_data = 8'h99;
        load_issue = 1'b1;  load_issue_rd = 4'd13;
        step();
        idle();
        check("t5_const_en", wb_enable,    0);
        check("t5_ro",       ro_violation, 1);
        check("t5_ro_mask",  pending_mask, 16'h0000);
        step();
        check("t5_lsu_en", wb_enable, 0);
        lsu_valid = 1'b1; lsu_rd_addr = 4'd4; lsu_data = 8'h44;
        step();
        idle();
        step();
        check("t5_next_en",   wb_enable,     1);
        check("t5_next_addr", wb_rd_address, 4);
        check("t5_next_data", wb_data,       8'h44);
        check("t5_ro_sticky", ro_violation,  1);

        // 6: reset while two loads are buffered
        alu_valid = 1'b1; alu_rd_addr = 4'd2; alu_data = 8'h01;
        lsu_valid = 1'b1; lsu_rd_addr = 4'd8; lsu_data = 8'h81;
        load_issue = 1'b1; load_issue_rd = 4'd8;
        step();
        idle();
        alu_valid = 1'b1; alu_rd_addr = 4'd2; alu_data = 8'h02;
        lsu_valid = 1'b1; lsu_rd_addr = 4'd9; lsu_data = 8'h92;
        step();
        idle();
        check("t6_full",     lsu_ready,    0);
        check("t6_pre_mask", pending_mask, 16'h0100);
        reset = 1'b0;
        step();
        check("t6_rst_ready", lsu_ready,    0);
        check("t6_rst_en",    wb_enable,    0);
        check("t6_rst_mask",  pending_mask, 16'h0000);
        check("t6_rst_ro",    ro_violation, 0);
        reset = 1'b1;
        step();
        check("t6_rel_en",    wb_enable, 0);
        check("t6_rel_ready", lsu_ready, 1);
        step();
        check("t6_no_stale", wb_enable, 0);
        step();
        check("t6_no_stale2", wb_enable, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
